// File: rtl/spi_ram_cmd_if.sv
// Word-level link between the SPI slave and the RAM command decoder.
// master = SPI slave side (drives rx words), slave = decoder side.
interface spi_ram_cmd_if;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       err_clr;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       proto_err;

    modport master (
        output rx_data, rx_valid, err_clr,
        input  tx_data, tx_valid, proto_err
    );

    modport slave (
        input  rx_data, rx_valid, err_clr,
        output tx_data, tx_valid, proto_err
    );
endinterface

// File: rtl/spi_ram_cmd.sv
// Single-port RAM behind a 2-bit command / 8-bit payload word stream, with
// sticky protocol error flag and optional address auto-increment.
module spi_ram_cmd #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned AUTO_INC  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_ram_cmd_if.slave  bus
);

    localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    // ST_HOLD: a read byte is presented and held until the next accepted word
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e                 r_state, w_state_nxt;
    logic [7:0]             r_tx_data, w_tx_data_nxt;
    logic                   r_tx_valid, w_tx_valid_nxt;
    logic                   r_proto_err, w_proto_err_nxt;
    logic [ADDR_SIZE-1:0]   r_wr_addr, w_wr_addr_nxt;
    logic [ADDR_SIZE-1:0]   r_rd_addr, w_rd_addr_nxt;
    logic                   r_wr_addr_ok, w_wr_addr_ok_nxt;
    logic                   r_rd_addr_ok, w_rd_addr_ok_nxt;
    logic                   w_mem_we;

    logic [7:0]             r_mem [MEM_DEPTH];

    cmd_e                   w_cmd;
    logic [7:0]             w_payload;
    logic [ADDR_SIZE-1:0]   w_addr;
    logic                   w_in_range;
    logic [ADDR_SIZE-1:0]   w_wr_inc;
    logic [ADDR_SIZE-1:0]   w_rd_inc;
    logic [7:0]             w_rd_word;

    assign w_cmd      = cmd_e'(bus.rx_data[9:8]);
    assign w_payload  = bus.rx_data[7:0];
    assign w_addr     = ADDR_SIZE'(w_payload);
    assign w_in_range = (9'(w_payload) < 9'(MEM_DEPTH));
    assign w_wr_inc   = (r_wr_addr == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : r_wr_addr + 1'b1;
    assign w_rd_inc   = (r_rd_addr == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : r_rd_addr + 1'b1;
    assign w_rd_word  = r_mem[MEM_AW'(r_rd_addr)];

    // Command decode and next-state
    always_comb begin
        w_state_nxt      = r_state;
        w_tx_data_nxt    = r_tx_data;
        w_proto_err_nxt  = r_proto_err & ~bus.err_clr;
        w_wr_addr_nxt    = r_wr_addr;
        w_rd_addr_nxt    = r_rd_addr;
        w_wr_addr_ok_nxt = r_wr_addr_ok;
        w_rd_addr_ok_nxt = r_rd_addr_ok;
        w_mem_we         = 1'b0;

        if (bus.rx_valid) begin
            w_state_nxt = ST_IDLE;
            case (w_cmd)
                CMD_WR_ADDR: begin
                    if (w_in_range) begin
                        w_wr_addr_nxt    = w_addr;
                        w_wr_addr_ok_nxt = 1'b1;
                    end else begin
                        w_proto_err_nxt  = 1'b1;
                    end
                end
                CMD_WR_DATA: begin
                    if (r_wr_addr_ok) begin
                        w_mem_we = 1'b1;
                        if (AUTO_INC != 0) w_wr_addr_nxt = w_wr_inc;
                    end else begin
                        w_proto_err_nxt = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    if (w_in_range) begin
                        w_rd_addr_nxt    = w_addr;
                        w_rd_addr_ok_nxt = 1'b1;
                    end else begin
                        w_proto_err_nxt  = 1'b1;
                    end
                end
                CMD_RD_DATA: begin
                    if (r_rd_addr_ok) begin
                        w_tx_data_nxt = w_rd_word;
                        w_state_nxt   = ST_HOLD;
                        if (AUTO_INC != 0) w_rd_addr_nxt = w_rd_inc;
                    end else begin
                        w_proto_err_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        w_tx_valid_nxt = (w_state_nxt == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_proto_err  <= 1'b0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_wr_addr_ok <= 1'b0;
            r_rd_addr_ok <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_tx_valid   <= w_tx_valid_nxt;
            r_proto_err  <= w_proto_err_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_wr_addr_ok <= w_wr_addr_ok_nxt;
            r_rd_addr_ok <= w_rd_addr_ok_nxt;
        end
    end

    // Storage array has no reset so it maps onto a RAM macro
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[MEM_AW'(r_wr_addr)] <= w_payload;
    end

    assign bus.tx_data   = r_tx_data;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.proto_err = r_proto_err;

endmodule

// File: tb/tb_spi_ram_cmd.sv
// Directed bench: three instances (default, AUTO_INC=1, MEM_DEPTH=128)
// share clock and reset; each scenario drives one instance.
module tb_spi_ram_cmd;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [9:0] rx_data  [3];
    logic       rx_valid [3];
    logic       err_clr  [3];
    logic [7:0] tx_d     [3];
    logic       tx_v     [3];
    logic       perr     [3];

    spi_ram_cmd_if if0 ();
    spi_ram_cmd_if if1 ();
    spi_ram_cmd_if if2 ();

    assign if0.rx_data = rx_data[0];  assign if0.rx_valid = rx_valid[0];  assign if0.err_clr = err_clr[0];
    assign if1.rx_data = rx_data[1];  assign if1.rx_valid = rx_valid[1];  assign if1.err_clr = err_clr[1];
    assign if2.rx_data = rx_data[2];  assign if2.rx_valid = rx_valid[2];  assign if2.err_clr = err_clr[2];
    assign tx_d[0] = if0.tx_data;  assign tx_v[0] = if0.tx_valid;  assign perr[0] = if0.proto_err;
    assign tx_d[1] = if1.tx_data;  assign tx_v[1] = if1.tx_valid;  assign perr[1] = if1.proto_err;
    assign tx_d[2] = if2.tx_data;  assign tx_v[2] = if2.tx_valid;  assign perr[2] = if2.proto_err;

    spi_ram_cmd #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    spi_ram_cmd #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    spi_ram_cmd #(.MEM_DEPTH(128), .ADDR_SIZE(8), .AUTO_INC(0)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One word to instance i, applied at negedge, sampled 1 ns after the edge
    task automatic send(input int i, input logic [1:0] c, input logic [7:0] p, input logic clr);
        @(negedge clk);
        rx_valid[i] = 1'b1;
        rx_data[i]  = {c, p};
        err_clr[i]  = clr;
        @(posedge clk);
        #1;
        rx_valid[i] = 1'b0;
        err_clr[i]  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++; if (tx_d[k] !== 8'h00) begin errors++; $display("FAIL reset_tx_data[%0d] got=%h exp=00", k, tx_d[k]); end
            checks++; if (tx_v[k] !== 1'b0)  begin errors++; $display("FAIL reset_tx_valid[%0d] got=%b exp=0", k, tx_v[k]); end
            checks++; if (perr[k] !== 1'b0)  begin errors++; $display("FAIL reset_proto_err[%0d] got=%b exp=0", k, perr[k]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_proto_err();
        send(0, 2'b01, 8'h11, 1'b0);
        checks++; if (perr[0] !== 1'b1) begin errors++; $display("FAIL perr_wr_noaddr got=%b exp=1", perr[0]); end
        send(0, 2'b11, 8'h00, 1'b0);
        checks++; if (tx_v[0] !== 1'b0) begin errors++; $display("FAIL perr_rd_noaddr_valid got=%b exp=0", tx_v[0]); end
        checks++; if (tx_d[0] !== 8'h00) begin errors++; $display("FAIL perr_rd_noaddr_data got=%h exp=00", tx_d[0]); end
        idle(2);
        checks++; if (perr[0] !== 1'b1) begin errors++; $display("FAIL perr_sticky got=%b exp=1", perr[0]); end
        @(negedge clk); err_clr[0] = 1'b1;
        @(posedge clk); #1; err_clr[0] = 1'b0;
        checks++; if (perr[0] !== 1'b0) begin errors++; $display("FAIL perr_clear got=%b exp=0", perr[0]); end
    endtask

    task automatic test_basic();
        send(0, 2'b00, 8'h2A, 1'b0);
        send(0, 2'b01, 8'h5C, 1'b0);
        send(0, 2'b10, 8'h2A, 1'b0);
        send(0, 2'b11, 8'h00, 1'b0);
        checks++; if (tx_v[0] !== 1'b1)  begin errors++; $display("FAIL basic_tx_valid got=%b exp=1", tx_v[0]); end
        checks++; if (tx_d[0] !== 8'h5C) begin errors++; $display("FAIL basic_tx_data got=%h exp=5c", tx_d[0]); end
        idle(9);
        checks++; if (tx_v[0] !== 1'b1)  begin errors++; $display("FAIL basic_hold_valid got=%b exp=1", tx_v[0]); end
        checks++; if (tx_d[0] !== 8'h5C) begin errors++; $display("FAIL basic_hold_data got=%h exp=5c", tx_d[0]); end
        checks++; if (perr[0] !== 1'b0)  begin errors++; $display("FAIL basic_proto_err got=%b exp=0", perr[0]); end
    endtask

    task automatic test_auto_inc();
        send(1, 2'b00, 8'hFF, 1'b0);
        send(1, 2'b01, 8'hA1, 1'b0);
        send(1, 2'b01, 8'hB2, 1'b0);
        send(1, 2'b10, 8'hFF, 1'b0);
        send(1, 2'b11, 8'h00, 1'b0);
        checks++; if (tx_v[1] !== 1'b1 || tx_d[1] !== 8'hA1) begin errors++; $display("FAIL autoinc_rd_ff got=%b/%h exp=1/a1", tx_v[1], tx_d[1]); end
        send(1, 2'b11, 8'h00, 1'b0);
        checks++; if (tx_v[1] !== 1'b1 || tx_d[1] !== 8'hB2) begin errors++; $display("FAIL autoinc_rd_wrap got=%b/%h exp=1/b2", tx_v[1], tx_d[1]); end
        checks++; if (perr[1] !== 1'b0) begin errors++; $display("FAIL autoinc_proto_err got=%b exp=0", perr[1]); end
    endtask

    task automatic test_range();
        send(2, 2'b00, 8'h05, 1'b0);
        checks++; if (perr[2] !== 1'b0) begin errors++; $display("FAIL range_ok got=%b exp=0", perr[2]); end
        send(2, 2'b00, 8'h90, 1'b0);
        checks++; if (perr[2] !== 1'b1) begin errors++; $display("FAIL range_wr_reject got=%b exp=1", perr[2]); end
        send(2, 2'b01, 8'h77, 1'b0);
        send(2, 2'b10, 8'h05, 1'b0);
        send(2, 2'b11, 8'h00, 1'b0);
        checks++; if (tx_v[2] !== 1'b1 || tx_d[2] !== 8'h77) begin errors++; $display("FAIL range_wr_kept got=%b/%h exp=1/77", tx_v[2], tx_d[2]); end
        @(negedge clk); err_clr[2] = 1'b1;
        @(posedge clk); #1; err_clr[2] = 1'b0;
        send(2, 2'b10, 8'h7F, 1'b0);
        checks++; if (perr[2] !== 1'b0 || tx_v[2] !== 1'b0) begin errors++; $display("FAIL range_top_ok got=%b/%b exp=0/0", perr[2], tx_v[2]); end
        send(2, 2'b10, 8'h05, 1'b0);
        send(2, 2'b10, 8'h80, 1'b0);
        checks++; if (perr[2] !== 1'b1) begin errors++; $display("FAIL range_rd_reject got=%b exp=1", perr[2]); end
        send(2, 2'b11, 8'h00, 1'b0);
        checks++; if (tx_d[2] !== 8'h77) begin errors++; $display("FAIL range_rd_kept got=%h exp=77", tx_d[2]); end
    endtask

    task automatic test_edge();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++; if (tx_v[0] !== 1'b0 || tx_d[0] !== 8'h00) begin errors++; $display("FAIL async_reset got=%b/%h exp=0/00", tx_v[0], tx_d[0]); end
        @(negedge clk); rst_n = 1'b1;
        send(0, 2'b11, 8'h00, 1'b1);
        checks++; if (perr[0] !== 1'b1 || tx_v[0] !== 1'b0) begin errors++; $display("FAIL err_beats_clr got=%b/%b exp=1/0", perr[0], tx_v[0]); end
        @(negedge clk); err_clr[0] = 1'b1;
        @(posedge clk); #1; err_clr[0] = 1'b0;
        send(0, 2'b10, 8'h11, 1'b0);
        send(0, 2'b00, 8'h11, 1'b0);
        send(0, 2'b01, 8'hE7, 1'b0);
        send(0, 2'b11, 8'h00, 1'b0);
        checks++; if (tx_v[0] !== 1'b1 || tx_d[0] !== 8'hE7) begin errors++; $display("FAIL raw_read got=%b/%h exp=1/e7", tx_v[0], tx_d[0]); end
        send(0, 2'b10, 8'h2A, 1'b0);
        checks++; if (tx_v[0] !== 1'b0 || tx_d[0] !== 8'hE7) begin errors++; $display("FAIL non_rd_clears got=%b/%h exp=0/e7", tx_v[0], tx_d[0]); end
        send(0, 2'b11, 8'h00, 1'b0);
        send(0, 2'b10, 8'h11, 1'b0);
        send(0, 2'b11, 8'h00, 1'b0);
        checks++; if (tx_v[0] !== 1'b1 || tx_d[0] !== 8'hE7) begin errors++; $display("FAIL rd_after_addr got=%b/%h exp=1/e7", tx_v[0], tx_d[0]); end
        send(0, 2'b10, 8'h2A, 1'b0);
        send(0, 2'b11, 8'h00, 1'b0);
        send(0, 2'b11, 8'h00, 1'b0);
        checks++; if (tx_v[0] !== 1'b1 || tx_d[0] !== 8'h5C) begin errors++; $display("FAIL b2b_rd got=%b/%h exp=1/5c", tx_v[0], tx_d[0]); end
        checks++; if (perr[0] !== 1'b0) begin errors++; $display("FAIL edge_proto_err got=%b exp=0", perr[0]); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int k = 0; k < 3; k++) begin
            rx_data[k]  = '0;
            rx_valid[k] = 1'b0;
            err_clr[k]  = 1'b0;
        end
        test_reset();
        test_proto_err();
        test_basic();
        test_auto_inc();
        test_range();
        test_edge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
